// File: rtl/axi4l_master_engine_if.sv
// AXI4-Lite bus bundle between the command engine (master) and an interconnect (slave).
// Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//           R (rdata/rresp/rvalid/rready).
interface axi4l_master_engine_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_master_engine.sv
// Single-outstanding AXI4-Lite master: one command in, one bus transaction, one response out.
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   cmd_*_i / cmd_ready_o    command stream (write flag, addr, wdata, wstrb, prot)
//   rsp_*_o / rsp_ready_i    response stream (write echo, rdata, resp code)
//   timeout_o, timeout_clr_i sticky bus-hang flag and its clear
//   m_axi                    AXI4-Lite master modport
module axi4l_master_engine #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  input  logic [2:0]              cmd_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_write_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output logic                    timeout_o,
  input  logic                    timeout_clr_i,
  axi4l_master_engine_if.master   m_axi
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  if (!((DATA_WIDTH == 32) || (DATA_WIDTH == 64))) begin : g_bad_data_width
    $error("axi4l_master_engine: DATA_WIDTH must be 32 or 64");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R, S_RSP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [2:0]            prot_q, prot_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  tcnt_q, tcnt_d;

  // State and output registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      timeout_q   <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      prot_q      <= prot_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      timeout_q   <= timeout_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Next-state, channel sequencing and hang timer
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    prot_d      = prot_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    timeout_d   = timeout_q;
    tcnt_d      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          wstrb_d = cmd_wstrb_i;
          prot_d  = cmd_prot_i;
          if (cmd_write_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_AR;
          end
        end
      end
      S_WR_AW_W: begin
        // AW and W retire independently; B opens only once both are gone
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end
      S_WR_B: begin
        if (bready_q && m_axi.bvalid) begin
          bready_d    = 1'b0;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi.bresp;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RD_AR: begin
        if (arvalid_q && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end
      S_RD_R: begin
        if (rready_q && m_axi.rvalid) begin
          rready_d    = 1'b0;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi.rdata;
          rsp_resp_d  = m_axi.rresp;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Saturating hang counter; only bus-wait states advance it
    if (state_q inside {S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R}) begin
      tcnt_d = (tcnt_q == CNT_MAX) ? tcnt_q : tcnt_q + CNT_WIDTH'(1);
    end

    // Setting only from a clear flag lets a clear show for one cycle, then re-arm
    if (timeout_clr_i) timeout_d = 1'b0;
    if (TO_EN && (tcnt_q == CNT_MAX) && !timeout_q) timeout_d = 1'b1;
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_write_o   = rsp_write_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_resp_o    = rsp_resp_q;
  assign timeout_o     = timeout_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = prot_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = prot_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_axi4l_master_engine.sv
// Bench for axi4l_master_engine: a reactive AXI4-Lite slave with per-channel ready/valid
// delays, a table of directed transactions, randomized transactions against a
// transaction-level expectation, and hand sequences for timeout and mid-transaction reset.
module tb_axi4l_master_engine;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cmd_valid, cmd_write, rsp_ready, timeout_clr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic [2:0]    cmd_prot;
  logic          cmd_ready, rsp_valid, rsp_write, timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  axi4l_master_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4l_master_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb), .cmd_prot_i(cmd_prot),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
    .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
    .timeout_o(timeout), .timeout_clr_i(timeout_clr),
    .m_axi(bus)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- slave model configuration and logs ----------------
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  int cyc = 0;
  int t0 = 0;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, proto_err = 0;
  int bready_first = -1;
  logic [31:0] log_awaddr, log_wdata, log_araddr;
  logic [3:0]  log_wstrb;
  logic [2:0]  log_awprot, log_arprot;

  int   aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit   aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0, bready_seen = 0;
  bit   aw_hold = 0, w_hold = 0, ar_hold = 0;
  logic [31:0] h_awaddr, h_wdata, h_araddr;
  logic [3:0]  h_wstrb;
  logic [2:0]  h_awprot, h_arprot;

  // Slave: drive responses at negedge, observe handshakes at posedge
  always begin
    @(negedge aclk);
    if (!aresetn) begin
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.bvalid  = 1'b0; bus.rvalid = 1'b0;
      bus.bresp   = 2'b00; bus.rresp = 2'b00; bus.rdata = '0;
    end else begin
      bus.awready = bus.awvalid && (aw_cnt >= cfg_aw_dly);
      bus.wready  = bus.wvalid && (w_cnt >= cfg_w_dly);
      bus.arready = bus.arvalid && (ar_cnt >= cfg_ar_dly);
      bus.bvalid  = b_pend && (b_cnt >= cfg_b_dly);
      bus.rvalid  = r_pend && (r_cnt >= cfg_r_dly);
      bus.bresp   = cfg_resp;
      bus.rresp   = cfg_resp;
      bus.rdata   = cfg_rdata;
    end
    @(posedge aclk);
    if (!aresetn) begin
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; bready_seen = 0;
      aw_hold = 0; w_hold = 0; ar_hold = 0;
    end else begin
      if (aw_hold && (!bus.awvalid || bus.awaddr !== h_awaddr || bus.awprot !== h_awprot)) proto_err++;
      if (w_hold && (!bus.wvalid || bus.wdata !== h_wdata || bus.wstrb !== h_wstrb)) proto_err++;
      if (ar_hold && (!bus.arvalid || bus.araddr !== h_araddr || bus.arprot !== h_arprot)) proto_err++;
      if ((bus.awvalid || bus.wvalid || bus.bready) && (bus.arvalid || bus.rready)) proto_err++;
      aw_hold = bus.awvalid && !bus.awready; h_awaddr = bus.awaddr; h_awprot = bus.awprot;
      w_hold  = bus.wvalid && !bus.wready;   h_wdata  = bus.wdata;  h_wstrb  = bus.wstrb;
      ar_hold = bus.arvalid && !bus.arready; h_araddr = bus.araddr; h_arprot = bus.arprot;

      if (bus.awvalid && bus.awready) begin
        n_aw++; log_awaddr = bus.awaddr; log_awprot = bus.awprot; aw_cnt = 0; aw_got = 1;
      end else if (bus.awvalid) aw_cnt++;
      if (bus.wvalid && bus.wready) begin
        n_w++; log_wdata = bus.wdata; log_wstrb = bus.wstrb; w_cnt = 0; w_got = 1;
      end else if (bus.wvalid) w_cnt++;

      if (bus.bready && !bready_seen) begin bready_first = cyc - t0; bready_seen = 1; end
      if (b_pend) begin
        if (bus.bvalid && bus.bready) begin n_b++; b_pend = 0; bready_seen = 0; end
        else if (!bus.bvalid) b_cnt++;
      end
      if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end

      if (r_pend) begin
        if (bus.rvalid && bus.rready) begin n_r++; r_pend = 0; end
        else if (!bus.rvalid) r_cnt++;
      end
      if (bus.arvalid && bus.arready) begin
        n_ar++; log_araddr = bus.araddr; log_arprot = bus.arprot; ar_cnt = 0;
        r_pend = 1; r_cnt = 0;
      end else if (bus.arvalid) ar_cnt++;
    end
    cyc++;
  end

  // ---------------- command / response drivers ----------------
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot);
    int n = 0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_wstrb = strb; cmd_prot = prot;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    chk("cmd_accept", cmd_ready, 1'b1);
    t0 = cyc;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int stall, output logic w, output logic [31:0] d,
                          output logic [1:0] r, output int lat);
    int n = 0;
    bit hold_ok = 1;
    while (!rsp_valid && n < 200) begin @(negedge aclk); n++; end
    chk("rsp_valid_seen", rsp_valid, 1'b1);
    lat = cyc - t0;
    w = rsp_write; d = rsp_rdata; r = rsp_resp;
    cmd_valid = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge aclk);
      if (!(rsp_valid && rsp_write == w && rsp_rdata == d && rsp_resp == r && !cmd_ready)) hold_ok = 0;
    end
    if (stall > 0) chk("rsp_hold_under_backpressure", hold_ok, 1'b1);
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("rsp_valid_drops", rsp_valid, 1'b0);
    chk("cmd_ready_after_rsp", cmd_ready, 1'b1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly, stall;
    logic [1:0]  sresp;
    logic [31:0] srdata;
    int          exp_lat;
    int          exp_bready;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic set_cfg(input int aw_d, input int w_d, input int b_d, input int ar_d,
                         input int r_d, input logic [1:0] resp, input logic [31:0] rdat);
    cfg_aw_dly = aw_d; cfg_w_dly = w_d; cfg_b_dly = b_d; cfg_ar_dly = ar_d; cfg_r_dly = r_d;
    cfg_resp = resp; cfg_rdata = rdat;
  endtask

  initial begin
    logic        rw;
    logic [31:0] rd;
    logic [1:0]  rr;
    int          lat, saw, sw, sar, sb, first;

    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,
                3, 2, 32'h0, 2'b00};
    vecs[1] = '{1'b1, 32'h20, 32'h0BADF00D, 4'h3, 3'h2, 4, 0, 0, 0, 0, 0, 2'b00, 32'h0,
                7, 6, 32'h0, 2'b00};
    vecs[2] = '{1'b0, 32'h30, 32'h0, 4'h0, 3'h5, 0, 0, 0, 3, 0, 0, 2'b10, 32'h12345678,
                6, -1, 32'h12345678, 2'b10};
    vecs[3] = '{1'b0, 32'h44, 32'h0, 4'h0, 3'h1, 0, 0, 0, 0, 1, 0, 2'b01, 32'hA5A5A5A5,
                4, -1, 32'hA5A5A5A5, 2'b01};
    vecs[4] = '{1'b1, 32'h58, 32'h11223344, 4'h9, 3'h7, 0, 2, 1, 0, 0, 4, 2'b11, 32'hFFFFFFFF,
                6, 4, 32'h0, 2'b11};
    vecs[5] = '{1'b1, 32'h6C, 32'hCAFE0001, 4'h1, 3'h4, 1, 0, 0, 0, 0, 1, 2'b01, 32'h0,
                4, 3, 32'h0, 2'b01};

    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0; timeout_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_axi_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_addr", bus.awaddr, 32'h0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);

    // Table-driven directed transactions
    for (int i = 0; i < NV; i++) begin
      set_cfg(vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly, vecs[i].ar_dly, vecs[i].r_dly,
              vecs[i].sresp, vecs[i].srdata);
      saw = n_aw; sw = n_w; sar = n_ar; sb = n_b;
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot);
      wait_rsp(vecs[i].stall, rw, rd, rr, lat);
      chk($sformatf("v%0d_rsp_write", i), rw, vecs[i].wr);
      chk($sformatf("v%0d_rsp_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_rsp_resp", i), rr, vecs[i].exp_resp);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_awaddr", i), log_awaddr, vecs[i].addr);
        chk($sformatf("v%0d_awprot", i), log_awprot, vecs[i].prot);
        chk($sformatf("v%0d_wdata", i), log_wdata, vecs[i].wdata);
        chk($sformatf("v%0d_wstrb", i), log_wstrb, vecs[i].strb);
        chk($sformatf("v%0d_hs_counts", i), {n_aw - saw, n_w - sw, n_b - sb, n_ar - sar},
            {32'd1, 32'd1, 32'd1, 32'd0});
        chk($sformatf("v%0d_bready_first", i), bready_first, vecs[i].exp_bready);
      end else begin
        chk($sformatf("v%0d_araddr", i), log_araddr, vecs[i].addr);
        chk($sformatf("v%0d_arprot", i), log_arprot, vecs[i].prot);
        chk($sformatf("v%0d_hs_counts", i), {n_aw - saw, n_ar - sar}, {32'd0, 32'd1});
      end
    end

    // Randomized transactions against a transaction-level expectation
    for (int i = 0; i < 30; i++) begin
      logic        wr;
      logic [31:0] a, wd, srd;
      logic [3:0]  st;
      logic [2:0]  pr;
      logic [1:0]  sr;
      wr = 1'(($urandom & 1));
      a = $urandom & 32'hFFFF_FFFC; wd = $urandom; st = 4'($urandom); pr = 3'($urandom);
      sr = 2'($urandom); srd = $urandom;
      set_cfg($urandom_range(2), $urandom_range(2), $urandom_range(2), $urandom_range(2),
              $urandom_range(2), sr, srd);
      saw = n_aw; sar = n_ar;
      issue(wr, a, wd, st, pr);
      wait_rsp($urandom_range(2), rw, rd, rr, lat);
      chk($sformatf("r%0d_rsp_write", i), rw, wr);
      chk($sformatf("r%0d_rsp_rdata", i), rd, wr ? 32'h0 : srd);
      chk($sformatf("r%0d_rsp_resp", i), rr, sr);
      if (wr) chk($sformatf("r%0d_aw_w", i), {log_awaddr, log_wdata, log_wstrb, log_awprot, n_aw - saw},
                  {a, wd, st, pr, 32'd1});
      else    chk($sformatf("r%0d_ar", i), {log_araddr, log_arprot, n_ar - sar}, {a, pr, 32'd1});
    end
    chk("no_timeout_on_short_waits", timeout, 1'b0);

    // Timeout: AR never accepted, then clear/re-assert, then complete
    set_cfg(0, 0, 0, 10000, 0, 2'b00, 32'hCAFEF00D);
    issue(1'b0, 32'h80, 32'h0, 4'h0, 3'h0);
    first = -1;
    for (int n = 0; n < 30 && first < 0; n++) begin
      if (timeout) first = cyc - t0;
      else @(negedge aclk);
    end
    chk("to_first_cycle_in_9_10", (first >= 9 && first <= 10), 1'b1);
    chk("to_arvalid_held", bus.arvalid, 1'b1);
    timeout_clr = 1'b1;
    @(negedge aclk);
    timeout_clr = 1'b0;
    chk("to_cleared", timeout, 1'b0);
    @(negedge aclk);
    chk("to_reasserted", timeout, 1'b1);
    chk("to_arvalid_still_held", bus.arvalid, 1'b1);
    cfg_ar_dly = 0;
    wait_rsp(0, rw, rd, rr, lat);
    chk("to_rsp_rdata", rd, 32'hCAFEF00D);
    chk("to_rsp_resp", rr, 2'b00);
    chk("to_sticky", timeout, 1'b1);
    timeout_clr = 1'b1;
    @(negedge aclk);
    timeout_clr = 1'b0;
    chk("to_clear_idle", timeout, 1'b0);

    // Reset while waiting in WR_B for a delayed B
    set_cfg(0, 0, 3, 0, 0, 2'b10, 32'h0);
    sb = n_b;
    issue(1'b1, 32'h90, 32'h55AA55AA, 4'hF, 3'h0);
    @(negedge aclk);
    @(negedge aclk);
    chk("rstmid_in_wr_b", bus.bready, 1'b1);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("rstmid_axi_cleared", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
    chk("rstmid_rsp_valid", rsp_valid, 1'b0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rstmid_cmd_ready", cmd_ready, 1'b1);
    chk("rstmid_no_b_hs", n_b - sb, 0);
    set_cfg(0, 0, 0, 0, 1, 2'b00, 32'h0F0F0F0F);
    issue(1'b0, 32'hA0, 32'h0, 4'h0, 3'h0);
    wait_rsp(0, rw, rd, rr, lat);
    chk("rstmid_read_resp", rr, 2'b00);
    chk("rstmid_read_data", rd, 32'h0F0F0F0F);
    chk("rstmid_read_write", rw, 1'b0);

    chk("axi_protocol_violations", proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi4l_master_engine.md
Name: axi4l_master_engine

Overview:
- Synthesizable AXI4-Lite master that turns a single-entry command stream (read or write) into bus transactions and returns one response per command.
- Sits between register-access logic (CSR sequencer, debug bridge) and an AXI4-Lite interconnect.
- Adds what the behavioural bus tasks do not have: independent AW/W handshakes, a write path, response buffering with backpressure, and a sticky bus-hang timeout.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr/cmd_addr.
- DATA_WIDTH, 32, data width; 32 or 64 only, otherwise elaboration error.
- TIMEOUT_CYCLES, 1024, bus-hang threshold in aclk cycles; 0 disables the timeout.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- cmd_prot  in  3  copied to awprot/arprot
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR
- timeout  out  1  sticky bus-hang flag
- timeout_clr  in  1  clears timeout
- awaddr/awprot/awvalid  out; awready  in  AXI write address channel
- wdata/wstrb/wvalid  out; wready  in  AXI write data channel
- bresp  in  2; bvalid  in; bready  out  AXI write response channel
- araddr/arprot/arvalid  out; arready  in  AXI read address channel
- rdata  in; rresp  in  2; rvalid  in; rready  out  AXI read data channel

Behaviour:
- Reset values (aresetn low at posedge):
  - State IDLE.
  - awvalid, wvalid, arvalid, bready, rready, rsp_valid, timeout all 0.
  - Address, data, strobe, prot and response registers all 0.
  - cmd_ready is 1 in the cycle after reset deasserts.
- Reset mid-transaction: aborts immediately to IDLE with all outputs at reset values. The system-level reset must reset the slave as well.
- All AXI and rsp outputs are registered. cmd_ready = (state == IDLE), combinational from state.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: on cmd accept, latch cmd fields.
  - Write: set awvalid=1 and wvalid=1 next cycle, go to WR_AW_W.
  - Read: set arvalid=1, go to RD_AR.
- WR_AW_W: awvalid and wvalid drop independently, each on its own handshake (valid & ready at posedge).
  - Either order is legal, as is the same cycle.
  - Once both have completed, go to WR_B with bready=1 on the next cycle.
  - Valid must never drop before its ready; addr/data/strb/prot stay stable while valid is high.
- WR_B: on bvalid & bready, capture bresp, set bready=0, rsp_write=1, rsp_rdata=0, rsp_valid=1, go to RSP.
- RD_AR: on arvalid & arready, set arvalid=0, rready=1, go to RD_R.
- RD_R: on rvalid & rready, capture rdata/rresp, set rready=0, rsp_write=0, rsp_valid=1, go to RSP.
- RSP: hold rsp_* stable until rsp_valid & rsp_ready, then go to IDLE.
  - rsp_valid falls and cmd_ready rises in the next cycle.
  - No command is accepted in the same cycle as the response handshake.
- Latency with slave readies held high:
  - Command accept at cycle 0; AW/W or AR valid in cycle 1.
  - Write: B handshake at cycle 2, rsp_valid at cycle 3.
  - Read: rvalid 1 cycle after AR handshake gives rsp_valid at cycle 4.
- One transaction outstanding at most. Read and write never overlap.
- Timeout:
  - Counter (width $clog2(TIMEOUT_CYCLES+1)) clears on leaving IDLE and increments each cycle in WR_AW_W/WR_B/RD_AR/RD_R.
  - It saturates at TIMEOUT_CYCLES; on reaching it, timeout is set to 1 next cycle.
  - The transaction is NOT aborted, to preserve AXI compliance.
  - timeout clears on timeout_clr or reset. If set and clear occur in the same cycle, set wins.
  - The counter is held at 0 in IDLE and RSP.
- RESP codes pass through unmodified, including EXOKAY.

Test Plan:
- Write with awready/wready/bvalid immediately high: cmd addr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> one AW and one W handshake with those values; rsp_valid at cycle 3, rsp_resp=00, rsp_write=1, rsp_rdata=0.
- Split AW/W: wready high at cycle 1, awready held low until cycle 5 -> wvalid drops after cycle 1, awvalid stays high through cycle 5, bready first high at cycle 6, exactly one response.
- Read with arready delayed 3 cycles, then rvalid carrying rdata=0x12345678 and rresp=10 -> rsp_rdata=0x12345678, rsp_resp=10, rsp_write=0; arvalid never drops early.
- Response backpressure: rsp_ready low for 4 cycles -> rsp_* held stable, cmd_ready stays 0 with cmd_valid high; cmd_ready=1 the cycle after the rsp handshake.
- Timeout, TIMEOUT_CYCLES=8, arready never asserted -> timeout=1 after 8 RD_AR cycles, arvalid still 1. Assert timeout_clr -> flag clears and re-asserts the next cycle since the counter is saturated. Then arready=1 -> normal completion.
- Reset during WR_B with bvalid pending -> next cycle all valids/readies=0 and state IDLE; a following read completes normally with OKAY.
